// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor built from one full-adder cell and one carry
//   flip-flop. It processes two WIDTH-bit operands LSB first, one bit per
//   clock. A Start/Busy/Done handshake controls each operation. S, Cout and
//   Ovf are registered and change only when an operation completes or on
//   reset. With WIDTH=1 the block behaves as a registered full adder.
//
// Ports
//   Clk    in   rising-edge clock
//   Rst_n  in   asynchronous active-low reset
//   Start  in   operation request, sampled only while idle
//   Sub    in   0: A+B+Cin, 1: A-B (A + ~B + 1, Cin ignored)
//   A, B   in   WIDTH-bit operands, sampled with Start
//   Cin    in   carry-in for add mode, sampled with Start
//   Busy   out  high while an operation is in progress (exactly WIDTH cycles)
//   Done   out  one-cycle pulse when S/Cout/Ovf update
//   S      out  registered sum/difference, held until the next completion
//   Cout   out  carry out of the MSB (subtract mode: 1 = no borrow)
//   Ovf    out  signed overflow = carry into MSB ^ carry out of MSB
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] acc_nxt;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single full-adder cell operating on the current LSBs of the operands.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = majority(a_sh[0], b_sh[0], carry);
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at
        // position 0. Written as shift+set so WIDTH=1 needs no special case.
        acc_nxt             = acc >> 1;
        acc_nxt[WIDTH-1]    = sum_bit;
    end

    assign Busy = (state == RUN);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            Done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh  <= A;
                        // Subtraction is A + ~B + 1: invert B here and seed
                        // the carry with 1.
                        b_sh  <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // On the MSB edge the carry FF still holds the carry
                        // into the MSB, so overflow is available directly
                        // (for WIDTH=1 that is the initial carry).
                        state <= IDLE;
                        Done  <= 1'b1;
                        S     <= acc_nxt;
                        Cout  <= carry_nxt;
                        Ovf   <= carry ^ carry_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, parametrised successor to the team's single-bit full adder.
- One full-adder cell plus a carry flip-flop adds or subtracts two WIDTH-bit operands, LSB first, one bit per clock.
- Start/Busy/Done handshake; results are registered.
- Used where adder area matters more than latency; WIDTH=1 degenerates to a registered full adder.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1); internal bit counter is clog2(WIDTH)+1 bits.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when Busy=0
- Sub  input  1  mode, sampled with Start: 0 = A+B+Cin, 1 = A-B (A + ~B + 1, Cin ignored)
- A  input  WIDTH  operand A, sampled with Start
- B  input  WIDTH  operand B, sampled with Start
- Cin  input  1  carry-in for add mode, sampled with Start
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse when results update
- S  output  WIDTH  registered sum/difference, held until the next completion
- Cout  output  1  carry out of the MSB; in Sub mode 1 = no borrow
- Ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (Rst_n=0, asynchronous): Busy=0, Done=0, S=0, Cout=0, Ovf=0, state IDLE, counter=0, internal shift registers=0.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
  - No separate DONE state; Done is a registered pulse.
- IDLE -> RUN at the edge where Start=1:
  - latch A; latch B, or ~B if Sub=1
  - carry FF <= (Sub ? 1 : Cin)
  - counter <= 0
- RUN, each edge:
  - sum bit = a0 ^ b0 ^ c; carry FF <= majority(a0, b0, c)
  - operand registers shift right; sum bit shifts into result register MSB
  - counter increments
  - on the edge processing bit WIDTH-2, the carry FF value (carry into MSB) is saved for Ovf
- Completion, at the edge processing bit WIDTH-1:
  - state -> IDLE, Busy -> 0, Done -> 1
  - S, Cout and Ovf load simultaneously at this edge
- Latency: Start sampled at edge 0; Done=1 and results valid after edge WIDTH; Busy high for exactly WIDTH cycles.
- Done is high for exactly one cycle, then 0.
- S, Cout and Ovf never change except at completion or reset. Intermediate bits are not visible on S.
- Start while Busy=1 is ignored; operands are not re-sampled.
- Start=1 in the cycle Done=1 (state IDLE) is accepted: back-to-back throughput of one result per WIDTH cycles.
- WIDTH=1:
  - completion at the first RUN edge
  - carry into MSB = initial carry, so Ovf = initial carry ^ Cout
- Reset asserted mid-RUN: aborts immediately, no Done pulse, all outputs zero; next Start operates normally.
- Arithmetic is modulo 2^WIDTH; the Cout/Ovf definitions hold in both modes.

Test Plan:
- WIDTH=8, Start with A=8'h5A, B=8'h33, Cin=0, Sub=0 -> Busy=1 for 8 cycles, Done one cycle after edge 8; S=8'h8D, Cout=0, Ovf=1.
- WIDTH=8, A=8'hFF, B=8'h01, Cin=1, Sub=0 -> S=8'h01, Cout=1, Ovf=0. Then A=8'h10, B=8'h20, Sub=1 issued in the Done cycle -> accepted back-to-back; S=8'hF0, Cout=0, Ovf=0.
- WIDTH=8, Sub=1, A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, Ovf=1. Start pulsed at cycle 3 of RUN with A=8'h00 -> ignored; result unchanged, single Done pulse.
- WIDTH=8, Rst_n low at RUN cycle 4 -> Busy, Done, S, Cout, Ovf all 0 asynchronously, no Done. After release, 8'h01+8'h01 -> S=8'h02.
- WIDTH=1, all 8 combinations of A, B, Cin (Sub=0) -> S = A^B^Cin, Cout = majority, matching the full-adder truth table; Done after 1 edge each.
- Outputs hold: after any completion, S, Cout and Ovf stay stable across 20 idle cycles with inputs toggling.
